// File: rtl/line_dec_pkg.sv
// Shared constants and types for the sequenced one-hot line decoder.
package line_dec_pkg;

  localparam int N_DEF       = 5;
  localparam int DWELL_W_DEF = 4;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SCAN
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-2^N one-hot decode.
module onehot_dec #(
  parameter int N = 5
) (
  input  logic [N-1:0]      addr,
  output logic [(1<<N)-1:0] d
);

  always_comb begin
    d       = '0;
    d[addr] = 1'b1;
  end

endmodule

// File: rtl/line_decoder_seq.sv
// Registered one-hot line select with static (DIRECT) and scanning modes.
module line_decoder_seq
  import line_dec_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_addr,
  input  logic               in_mode,
  input  logic [DWELL_W-1:0] in_dwell,
  input  logic               en,
  input  logic               clear,
  output logic [(1<<N)-1:0]  out_d,
  output logic [N-1:0]       out_addr,
  output logic               busy,
  output logic               wrap
);

  localparam int L = 1 << N;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell;
  logic               accept;
  logic               adv;
  logic [N-1:0]       addr_nxt;
  logic [L-1:0]       line;

  assign in_ready = (state != SCAN) & ~clear;
  assign accept   = in_valid & in_ready;
  assign adv      = (state == SCAN) & en & (cnt == '0);

  always_comb begin
    addr_nxt = out_addr;
    if (accept)   addr_nxt = in_addr;
    else if (adv) addr_nxt = out_addr + 1'b1;
  end

  onehot_dec #(.N(N)) u_dec (
    .addr (addr_nxt),
    .d    (line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dwell    <= '0;
      out_d    <= '0;
      out_addr <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        cnt      <= '0;
        out_d    <= '0;
        out_addr <= '0;
        busy     <= 1'b0;
      end else if (accept) begin
        out_d    <= line;
        out_addr <= addr_nxt;
        if (in_mode == MODE_SCAN) begin
          state <= SCAN;
          busy  <= 1'b1;
          cnt   <= in_dwell;
          dwell <= in_dwell;
        end else begin
          state <= HOLD;
          busy  <= 1'b0;
        end
      end else if (state == SCAN && en) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          out_d    <= line;
          out_addr <= addr_nxt;
          cnt      <= dwell;
          wrap     <= (addr_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_decoder_seq.sv
// Self-checking bench for line_decoder_seq (N=5, DWELL_W=4).
module tb_line_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr = '0;
  logic        in_mode = 1'b0;
  logic [3:0]  in_dwell = '0;
  logic        en = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] out_d;
  logic [4:0]  out_addr;
  logic        busy;
  logic        wrap;

  int n_chk = 0;
  int n_pass = 0;

  line_decoder_seq #(.N(5), .DWELL_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_mode  (in_mode),
    .in_dwell (in_dwell),
    .en       (en),
    .clear    (clear),
    .out_d    (out_d),
    .out_addr (out_addr),
    .busy     (busy),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Spec-level scan position: line index after k enabled cycles.
  function automatic int scan_addr(int start, int d, int k);
    return (start + k / (d + 1)) % 32;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (out_d !== 32'd0 || out_addr !== 5'd0 || busy !== 1'b0 || wrap !== 1'b0)
      $display("FAIL reset_init got d=%h a=%0d b=%b w=%b want all 0", out_d, out_addr, busy, wrap);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready);
    else n_pass++;
    in_valid = 1'b1; in_mode = 1'b1; in_addr = 5'd9; in_dwell = 4'd0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_d !== 32'd0 || out_addr !== 5'd0 || busy !== 1'b0 || wrap !== 1'b0)
      $display("FAIL reset_async got d=%h a=%0d b=%b w=%b want all 0", out_d, out_addr, busy, wrap);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_direct();
    logic [4:0]  a;
    logic [31:0] e;
    in_valid = 1'b1; in_mode = 1'b0; in_addr = 5'd13;
    tick();
    n_chk++;
    if (out_d !== 32'h0000_2000 || out_addr !== 5'd13 || busy !== 1'b0)
      $display("FAIL direct13 got d=%h a=%0d b=%b want 00002000 13 0", out_d, out_addr, busy);
    else n_pass++;
    in_addr = 5'd31;
    tick();
    n_chk++;
    if (out_d !== 32'h8000_0000 || out_addr !== 5'd31)
      $display("FAIL direct31 got d=%h a=%0d want 80000000 31", out_d, out_addr);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      a = 5'($urandom_range(0, 31));
      e = 32'd1 << a;
      in_valid = 1'b1; in_addr = a; en = 1'($urandom);
      tick();
      in_valid = 1'b0; in_addr = 5'($urandom);
      n_chk++;
      if (out_d !== e || out_addr !== a || busy !== 1'b0)
        $display("FAIL direct_rand got d=%h a=%0d want %h %0d", out_d, out_addr, e, a);
      else n_pass++;
      tick();
      n_chk++;
      if (out_d !== e || in_ready !== 1'b1)
        $display("FAIL direct_hold got d=%h r=%b want %h 1", out_d, in_ready, e);
      else n_pass++;
    end
    en = 1'b1;
  endtask

  task automatic test_clear_accept();
    in_valid = 1'b1; in_mode = 1'b0; in_addr = 5'd3;
    tick();
    clear = 1'b1; in_addr = 5'd7;
    #1;
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL clear_ready got %b want 0", in_ready);
    else n_pass++;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    #1;
    n_chk++;
    if (out_d !== 32'd0 || out_addr !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clear_hold got d=%h a=%0d b=%b r=%b want 0 0 0 1", out_d, out_addr, busy, in_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (out_d !== 32'd0) $display("FAIL clear_noconsume got d=%h want 0", out_d);
    else n_pass++;
  endtask

  task automatic test_scan(string nm, int start, int d, int cycles,
                           int stall_k, int stall_len, bit rnd_en);
    int          k = 0;
    int          stalled = 0;
    int          ea;
    bit          ew;
    logic [31:0] e;
    in_valid = 1'b1; in_mode = 1'b1; in_addr = 5'(start); in_dwell = 4'(d); en = 1'b1;
    tick();
    for (int c = 0; c < cycles; c++) begin
      if (c > 0) begin
        if (rnd_en) en = ($urandom_range(0, 3) != 0);
        else if (k == stall_k && stalled < stall_len) begin
          en = 1'b0; stalled++;
        end else en = 1'b1;
        in_valid = 1'($urandom); in_mode = 1'($urandom); in_addr = 5'($urandom);
        tick();
        if (en) k++;
      end else begin
        in_valid = 1'b0;
      end
      ea = scan_addr(start, d, k);
      ew = (c > 0) && en && (k % (d + 1) == 0) && (ea == 0);
      e  = 32'd1 << ea;
      n_chk++;
      if (out_addr !== 5'(ea) || out_d !== e || wrap !== ew || busy !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL %s c=%0d got a=%0d d=%h w=%b b=%b r=%b want a=%0d d=%h w=%b b=1 r=0",
                 nm, c, out_addr, out_d, wrap, busy, in_ready, ea, e, ew);
      else n_pass++;
    end
    in_valid = 1'b0; en = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || out_d !== 32'd0 || wrap !== 1'b0)
      $display("FAIL %s_clear got b=%b d=%h w=%b want 0 0 0", nm, busy, out_d, wrap);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_clear_accept();
    test_scan("scan_dwell2", 30, 2, 10, -1, 0, 1'b0);
    test_scan("scan_wrap", 0, 0, 34, -1, 0, 1'b0);
    test_scan("scan_stall", 0, 1, 16, 8, 5, 1'b0);
    for (int i = 0; i < 3; i++)
      test_scan("scan_rand", $urandom_range(0, 31), $urandom_range(0, 3), 80, -1, 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_decoder_seq.md
Name: line_decoder_seq

Overview:
- Parametrised, registered N-to-2^N one-hot line decoder with a valid/ready input handshake.
- Two modes. DIRECT latches a single decoded line. SCAN walks the one-hot output through all lines, holding each line for a programmable dwell time.
- Successor to the fixed 5-to-32 combinational decoder. Drives row/strobe select fabrics that need either a static select or an automatic scan.

Parameters:
- N, 5: address width; 2^N output lines; legal range 1..8.
- DWELL_W, 4: width of the per-line dwell count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_addr  in  N  DIRECT: line to select; SCAN: start line.
- in_mode  in  1  0 = DIRECT, 1 = SCAN; sampled on accept.
- in_dwell  in  DWELL_W  extra cycles each line is held in SCAN; sampled on accept.
- en  in  1  0 freezes scan progress.
- clear  in  1  synchronous abort; returns to IDLE.
- out_d  out  2^N  registered one-hot line select.
- out_addr  out  N  binary index of the active line.
- busy  out  1  scan in progress.
- wrap  out  1  one-cycle pulse when the scan index wraps from 2^N-1 to 0.

Behaviour:
- Reset (async, rst_n=0):
  - out_d=0, out_addr=0, busy=0, wrap=0.
  - Dwell counter=0; state=IDLE.
- State machine has three states: IDLE, HOLD, SCAN.
- in_ready = (state != SCAN) & ~clear. This is combinational.
- A request is accepted when in_valid & in_ready at a rising edge.
- Accept with in_mode=0:
  - Next cycle: out_d = 1<<in_addr, out_addr = in_addr; state = HOLD.
  - Latency is 1 cycle.
  - HOLD keeps the output static. A new DIRECT or SCAN accept is permitted in HOLD.
- Accept with in_mode=1:
  - Next cycle: out_d = 1<<in_addr, out_addr = in_addr.
  - Dwell counter = in_dwell; busy=1; state = SCAN.
- SCAN, each cycle with en=1:
  - If dwell counter != 0, decrement it.
  - Otherwise advance: out_addr += 1 modulo 2^N, out_d follows, counter reloads the latched dwell.
  - Each line is therefore held for dwell+1 cycles; dwell=0 advances every cycle.
- Wrap: on the advance from 2^N-1 to 0, wrap=1 for exactly the cycle in which out_addr=0 first appears. wrap is 0 at all other times.
- en=0: dwell counter and out_addr freeze and out_d holds. en does not gate accepts or clear.
- clear=1 (any state):
  - Next cycle: out_d=0, out_addr=0, busy=0, wrap=0; state = IDLE.
  - clear has priority over a simultaneous accept and over a scan advance.
  - in_ready is 0 while clear=1, so no request is consumed.
- SCAN runs until clear; in_valid is ignored in SCAN (in_ready=0).
- out_addr arithmetic is N-bit unsigned with natural wrap. No out-of-range index exists.
- Reset asserted mid-scan returns immediately to the reset values. It does not wait for a clock edge.
- N=1: 2 lines; wrap pulses on every second advance.

Decomposition:
- Shared package line_dec_pkg holds:
  - the mode constants MODE_DIRECT = 0 and MODE_SCAN = 1;
  - the state enum {IDLE, HOLD, SCAN};
  - the default N and DWELL_W.
- Sub-module onehot_dec: purely combinational, parametrised N-to-2^N one-hot decode, instantiated once on the next-state address. All registers live in line_decoder_seq.

Test Plan (N=5, DWELL_W=4):
- Reset: assert rst_n=0 mid-cycle -> out_d=0, out_addr=0, busy=0, wrap=0 immediately; in_ready=1 after release.
- DIRECT: accept addr=13, mode=0 -> next cycle out_d=32'h0000_2000, out_addr=13, busy=0; then accept addr=31 from HOLD -> out_d=32'h8000_0000.
- SCAN dwell=2 from addr=30:
  - out_addr sequence is 30,30,30,31,31,31,0,0,0,1.
  - wrap=1 only in the first cycle out_addr=0.
  - in_ready=0 throughout.
- SCAN dwell=0 from addr=0 for 33 cycles -> out_addr increments every cycle; wrap pulses once, at cycle 32.
- en stall: during a dwell=1 scan, drop en for 5 cycles at out_addr=4 -> out_addr stays 4 and the counter is frozen; resume completes the remaining dwell before advancing to 5.
- clear vs accept: in HOLD, assert clear and in_valid (addr=7) together -> in_ready=0, next cycle out_d=0, state IDLE; clear during a scan -> busy=0 next cycle.
